// File: rtl/sprinkler_zone_sequencer.sv
// sprinkler_zone_sequencer
//   Steps through up to eight irrigation zones in ascending order. Each enabled
//   zone is watered for ZONE_TICKS cycles. The block drives the enable and the
//   3-bit select inputs of a 3-to-8 valve decoder.
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      one-cycle run request; accepted only when idle
//   stop       abort the current run; acted on only while watering
//   skip       end the current zone early; acted on only while watering
//   zone_mask  bit i enables zone i; captured when start is accepted
//   E          decoder enable, high only while watering
//   A,B,C      zone index, A = MSB, C = LSB
//   busy       high while watering
//   done       one-cycle pulse when a run completes normally
module sprinkler_zone_sequencer #(
  parameter int ZONE_TICKS = 16,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       skip,
  input  logic [7:0] zone_mask,
  output logic       E,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_WATER, S_DONE} state_e;

  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(ZONE_TICKS - 1);

  state_e           state_q;
  logic [7:0]       mask_q;
  logic [2:0]       zone_q;
  logic [CNT_W-1:0] timer_q;

  // Lowest enabled zone of the incoming mask (used when a run starts).
  logic [2:0] first_zone;
  // Enabled zones strictly above the current one, and the lowest of them.
  logic [7:0] above;
  logic [2:0] next_zone;
  logic       zone_end;

  always_comb begin
    first_zone = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (zone_mask[i]) first_zone = 3'(i);
  end

  // (2 << zone) - 1 covers bits 0..zone; for zone 7 the shift wraps to 0 and
  // the subtraction yields all ones, so nothing is left above the last zone.
  assign above = mask_q & ~((8'd2 << zone_q) - 8'd1);

  always_comb begin
    next_zone = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (above[i]) next_zone = 3'(i);
  end

  assign zone_end = skip || (timer_q == LAST_TICK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mask_q  <= 8'd0;
      zone_q  <= 3'd0;
      timer_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mask_q  <= zone_mask;
            timer_q <= '0;
            if (|zone_mask) begin
              zone_q  <= first_zone;
              state_q <= S_WATER;
            end else begin
              state_q <= S_DONE;
            end
          end
        end
        S_WATER: begin
          if (stop) begin
            state_q <= S_IDLE;
            zone_q  <= 3'd0;
            timer_q <= '0;
          end else if (zone_end) begin
            timer_q <= '0;
            if (|above) zone_q  <= next_zone;
            else        state_q <= S_DONE;
          end else begin
            timer_q <= timer_q + CNT_W'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs decode only from registered state and zone.
  assign E         = (state_q == S_WATER);
  assign busy      = (state_q == S_WATER);
  assign done      = (state_q == S_DONE);
  assign {A, B, C} = zone_q;

endmodule

// File: tb/tb_sprinkler_zone_sequencer.sv
// Scoreboard bench: two DUT copies (ZONE_TICKS=4 and ZONE_TICKS=1) share the
// same stimulus. A run-level reference model (queue of zones still to water,
// ticks left in the current zone) predicts the outputs after every edge and
// pushes them; a monitor pops and compares one cycle's outputs per edge.
module tb_sprinkler_zone_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, skip = 1'b0;
  logic [7:0] zone_mask = 8'd0;
  logic [1:0] e_o, a_o, b_o, c_o, busy_o, done_o;

  always #5 clk = ~clk;

  sprinkler_zone_sequencer #(.ZONE_TICKS(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .skip(skip),
    .zone_mask(zone_mask), .E(e_o[0]), .A(a_o[0]), .B(b_o[0]), .C(c_o[0]),
    .busy(busy_o[0]), .done(done_o[0]));

  sprinkler_zone_sequencer #(.ZONE_TICKS(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .skip(skip),
    .zone_mask(zone_mask), .E(e_o[1]), .A(a_o[1]), .B(b_o[1]), .C(c_o[1]),
    .busy(busy_o[1]), .done(done_o[1]));

  // Reference model state, one set per DUT copy.
  int         zt [2] = '{4, 1};
  bit         wat [2];
  bit         donep [2];
  int         zone [2];
  int         ticks [2];
  int         rem [2][$];
  logic [5:0] exp_q [2][$];

  int checks = 0;
  int errors = 0;

  task automatic model_edge(input bit r, input bit s, input bit st,
                            input bit sk, input logic [7:0] m);
    logic [2:0] z;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        wat[i] = 0; donep[i] = 0; zone[i] = 0; rem[i].delete();
      end else if (wat[i]) begin
        if (st) begin
          wat[i] = 0; zone[i] = 0; rem[i].delete();
        end else if (sk || ticks[i] == 1) begin
          if (rem[i].size() > 0) begin
            zone[i]  = rem[i].pop_front();
            ticks[i] = zt[i];
          end else begin
            wat[i] = 0; donep[i] = 1;
          end
        end else begin
          ticks[i]--;
        end
      end else if (donep[i]) begin
        donep[i] = 0;
      end else if (s) begin
        rem[i].delete();
        for (int b = 0; b < 8; b++) if (m[b]) rem[i].push_back(b);
        if (rem[i].size() == 0) begin
          donep[i] = 1;
        end else begin
          zone[i]  = rem[i].pop_front();
          ticks[i] = zt[i];
          wat[i]   = 1;
        end
      end
      z = 3'(zone[i]);
      exp_q[i].push_back({wat[i], z, wat[i], donep[i]});
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit st, input bit sk,
                     input logic [7:0] m);
    @(negedge clk);
    rst = r; start = s; stop = st; skip = sk; zone_mask = m;
    @(posedge clk);
    model_edge(r, s, st, sk, m);
  endtask

  task automatic idle(input int n, input logic [7:0] m);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, m);
  endtask

  // Monitor: outputs are valid every cycle, compare each one.
  initial begin
    logic [5:0] exp_v, got;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (exp_q[i].size() > 0) begin
          exp_v = exp_q[i].pop_front();
          got   = {e_o[i], a_o[i], b_o[i], c_o[i], busy_o[i], done_o[i]};
          checks++;
          if (got !== exp_v) begin
            errors++;
            $display("FAIL outputs dut%0d t=%0t {E,A,B,C,busy,done} got=%b exp=%b",
                     i, $time, got, exp_v);
          end
        end
      end
    end
  end

  initial begin
    // reset state
    cyc(1, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 8'h00);
    idle(2, 8'h00);
    // full mask run
    cyc(0, 1, 0, 0, 8'hFF);
    idle(36, 8'hFF);
    // sparse mask: zones 1,5,7
    cyc(0, 1, 0, 0, 8'hA2);
    idle(16, 8'hA2);
    // empty mask: done next cycle, E never set
    cyc(0, 1, 0, 0, 8'h00);
    idle(3, 8'h00);
    // skip in zone 0, then stop+skip together later
    cyc(0, 1, 0, 0, 8'hFF);
    idle(1, 8'hFF);
    cyc(0, 0, 0, 1, 8'hFF);
    idle(9, 8'hFF);
    cyc(0, 0, 1, 1, 8'hFF);
    idle(3, 8'hFF);
    // start ignored mid-run, mask change mid-run, reset during zone 4
    cyc(0, 1, 0, 0, 8'hFF);
    idle(3, 8'hFF);
    cyc(0, 1, 0, 0, 8'h01);
    idle(5, 8'h3C);
    cyc(0, 1, 0, 0, 8'h00);
    idle(7, 8'h00);
    cyc(1, 0, 0, 0, 8'h00);
    idle(3, 8'h00);
    // first and last zone only
    cyc(0, 1, 0, 0, 8'h81);
    idle(10, 8'h81);
    // start on the IDLE cycle right after done
    cyc(0, 1, 0, 0, 8'h04);
    idle(5, 8'h04);
    cyc(0, 1, 0, 0, 8'h80);
    idle(6, 8'h80);
    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      bit         r, s, st, sk;
      logic [7:0] m;
      r  = ($urandom_range(0, 299) == 0);
      s  = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 59) == 0);
      sk = ($urandom_range(0, 11) == 0);
      m  = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      cyc(r, s, st, sk, m);
    end
    idle(2, 8'h00);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL drain dut%0d pending=%0d exp=0", i, exp_q[i].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
